alu_share_arbiter: RTL and testbench

//  Shares one combinational alu instance (ALU_In_A/B, ALU_OP -> ALU_Out, ALU_Zero_Flag)

---
 rtl/alu_share_arbiter_if.sv | 34 +++
 rtl/alu_share_arbiter.sv | 66 ++++++
 tb/tb_alu_share_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request, ALU-drive and response signals of the shared-ALU arbiter.
// slave is the arbiter's view; master is the surrounding core (requesters, ALU, consumer).
interface alu_share_arbiter_if #(parameter int DWIDTH = 32);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DWIDTH-1:0] req0_a;
    logic [DWIDTH-1:0] req0_b;
    logic [3:0]        req0_op;
    logic [DWIDTH-1:0] req1_a;
    logic [DWIDTH-1:0] req1_b;
    logic [3:0]        req1_op;
    logic [DWIDTH-1:0] alu_in_a;
    logic [DWIDTH-1:0] alu_in_b;
    logic [3:0]        alu_op;
    logic [DWIDTH-1:0] alu_out;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DWIDTH-1:0] rsp_data;
    logic              rsp_zero;
    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        input  alu_out, alu_zero, rsp_ready,
        output req_ready, alu_in_a, alu_in_b, alu_op,
        output rsp_valid, rsp_id, rsp_data, rsp_zero
    );
    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        output alu_out, alu_zero, rsp_ready,
        input  req_ready, alu_in_a, alu_in_b, alu_op,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Define ALU_ARB_PERF_EN to add per-requester accept counters perf_cnt0_o/perf_cnt1_o.
module alu_share_arbiter #(parameter int DWIDTH = 32) (
    input  logic clk_i,
    input  logic rst_n_i,
`ifdef ALU_ARB_PERF_EN
    output logic [31:0] perf_cnt0_o,
    output logic [31:0] perf_cnt1_o,
`endif
    alu_share_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} slot_e;
    slot_e             slot_q, slot_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic              zero_q, zero_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              accept, g;
    // The held result leaves the slot in the same cycle a new one may enter it.
    always_comb begin
        g = (&bus.req_valid) ? ~last_q : bus.req_valid[1];
        accept = rst_n_i && (|bus.req_valid) && (slot_q == EMPTY || bus.rsp_ready);
        bus.req_ready = accept ? (g ? 2'b10 : 2'b01) : 2'b00;
        bus.alu_in_a = !accept ? '0 : g ? bus.req1_a : bus.req0_a;
        bus.alu_in_b = !accept ? '0 : g ? bus.req1_b : bus.req0_b;
        bus.alu_op = !accept ? 4'd0 : g ? bus.req1_op : bus.req0_op;
        slot_d = accept ? FULL : bus.rsp_ready ? EMPTY : slot_q;
        last_d = accept ? g : last_q;
        id_d = accept ? g : id_q;
        data_d = accept ? bus.alu_out : data_q;
        zero_d = accept ? bus.alu_zero : zero_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_q <= EMPTY;
            last_q <= 1'b1;
            id_q   <= 1'b0;
            data_q <= '0;
            zero_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            last_q <= last_d;
            id_q   <= id_d;
            data_q <= data_d;
            zero_q <= zero_d;
        end
    end
    assign bus.rsp_valid = slot_q == FULL;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_zero  = zero_q;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf0_q, perf1_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf0_q <= '0;
            perf1_q <= '0;
        end else begin
            perf0_q <= perf0_q + {31'b0, accept & ~g};
            perf1_q <= perf1_q + {31'b0, accept & g};
        end
    end
    assign perf_cnt0_o = perf0_q;
    assign perf_cnt1_o = perf1_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random checks of the shared-ALU arbiter against a reference model.
// Build with +define+ALU_ARB_PERF_EN to also check the accept counters.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    alu_share_arbiter_if #(.DWIDTH(32)) bus();
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf0, perf1;
`endif
    alu_share_arbiter #(.DWIDTH(32)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
`ifdef ALU_ARB_PERF_EN
        .perf_cnt0_o(perf0),
        .perf_cnt1_o(perf1),
`endif
        .bus(bus)
    );
    always #5 clk = ~clk;

    // Software ALU: also plays the external ALU attached to the arbiter.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $signed(a) >>> b[4:0];
            4'd8: return {31'b0, $signed(a) < $signed(b)};
            4'd9: return {31'b0, a < b};
            default: return 32'd0;
        endcase
    endfunction
    assign bus.alu_out  = alu_f(bus.alu_in_a, bus.alu_in_b, bus.alu_op);
    assign bus.alu_zero = bus.alu_out == 32'd0;

    logic [31:0] fa [2];
    logic [31:0] fb [2];
    logic [3:0]  fo [2];
    logic        m_full, m_last, m_id, m_zero;
    logic [31:0] m_data;
    logic [31:0] m_cnt [2];
    logic        acc, gnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts just after a rising edge and ends just after the next one.
    task automatic cycle(input logic [1:0] vld, input logic rdy);
        bus.req_valid = vld;
        bus.rsp_ready = rdy;
        bus.req0_a = fa[0]; bus.req0_b = fb[0]; bus.req0_op = fo[0];
        bus.req1_a = fa[1]; bus.req1_b = fb[1]; bus.req1_op = fo[1];
        #4;
        acc = (!m_full || rdy) && vld != 2'b00;
        gnt = (vld == 2'b11) ? !m_last : vld[1];
        chk("req_ready", {30'b0, bus.req_ready}, acc ? (gnt ? 32'd2 : 32'd1) : 32'd0);
        chk("alu_in_a", bus.alu_in_a, acc ? fa[gnt] : 32'd0);
        chk("alu_in_b", bus.alu_in_b, acc ? fb[gnt] : 32'd0);
        chk("alu_op", {28'b0, bus.alu_op}, acc ? {28'b0, fo[gnt]} : 32'd0);
        @(posedge clk);
        #1;
        if (acc) begin
            m_full = 1'b1;
            m_id = gnt;
            m_last = gnt;
            m_data = alu_f(fa[gnt], fb[gnt], fo[gnt]);
            m_zero = m_data == 32'd0;
            m_cnt[gnt] = m_cnt[gnt] + 32'd1;
        end else if (rdy) begin
            m_full = 1'b0;
        end
        chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_full});
        chk("rsp_id", {31'b0, bus.rsp_id}, {31'b0, m_id});
        chk("rsp_data", bus.rsp_data, m_data);
        chk("rsp_zero", {31'b0, bus.rsp_zero}, {31'b0, m_zero});
`ifdef ALU_ARB_PERF_EN
        chk("perf_cnt0", perf0, m_cnt[0]);
        chk("perf_cnt1", perf1, m_cnt[1]);
`endif
    endtask

    // Asserts reset asynchronously partway through a cycle.
    task automatic apply_reset();
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {30'b0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'b0, bus.rsp_id}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_zero", {31'b0, bus.rsp_zero}, 32'd0);
        m_full = 1'b0; m_last = 1'b1; m_id = 1'b0; m_data = 32'd0; m_zero = 1'b0;
        m_cnt[0] = 32'd0; m_cnt[1] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  vld;
        logic [1:0]  pend;
        logic [31:0] held;
        int n, cyc;
        for (int i = 0; i < 2; i++) begin
            fa[i] = 32'd0; fb[i] = 32'd0; fo[i] = 4'd0;
        end
        #1;
        apply_reset();
        fa[0] = 32'd5; fb[0] = 32'd3; fo[0] = 4'd0;
        cycle(2'b01, 1'b1);
        chk("t1_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("t1_id", {31'b0, bus.rsp_id}, 32'd0);
        chk("t1_data", bus.rsp_data, 32'd8);
        chk("t1_zero", {31'b0, bus.rsp_zero}, 32'd0);
        apply_reset();
        fa[0] = 32'd7; fb[0] = 32'd7; fo[0] = 4'd1;
        fa[1] = 32'hF0; fb[1] = 32'h0F; fo[1] = 4'd3;
        cycle(2'b11, 1'b1);
        chk("t2_id_first", {31'b0, bus.rsp_id}, 32'd0);
        chk("t2_data_first", bus.rsp_data, 32'd0);
        chk("t2_zero_first", {31'b0, bus.rsp_zero}, 32'd1);
        cycle(2'b11, 1'b1);
        chk("t2_id_second", {31'b0, bus.rsp_id}, 32'd1);
        chk("t2_data_second", bus.rsp_data, 32'hFF);
        chk("t2_zero_second", {31'b0, bus.rsp_zero}, 32'd0);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(2'b11, 1'b1);
            chk("t3_id_seq", {31'b0, bus.rsp_id}, i % 2);
        end
`ifdef ALU_ARB_PERF_EN
        chk("t6_perf0_after_t3", perf0, 32'd3);
        chk("t6_perf1_after_t3", perf1, 32'd3);
`endif
        held = bus.rsp_data;
        for (int i = 0; i < 3; i++) begin
            cycle(2'b11, 1'b0);
            chk("t4_stall_ready", {30'b0, bus.req_ready}, 32'd0);
            chk("t4_stall_data", bus.rsp_data, held);
            chk("t4_stall_id", {31'b0, bus.rsp_id}, 32'd1);
        end
        fa[0] = 32'd100; fb[0] = 32'd1; fo[0] = 4'd1;
        cycle(2'b11, 1'b1);
        chk("t4_refill_id", {31'b0, bus.rsp_id}, 32'd0);
        chk("t4_refill_data", bus.rsp_data, 32'd99);
        chk("t5_full_before_reset", {31'b0, bus.rsp_valid}, 32'd1);
        apply_reset();
        cycle(2'b11, 1'b1);
        chk("t5_first_tie_id", {31'b0, bus.rsp_id}, 32'd0);
`ifdef ALU_ARB_PERF_EN
        bus.req_valid = 2'b00;
        force dut.perf0_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf0_q;
        m_cnt[0] = 32'hFFFF_FFFF;
        cycle(2'b01, 1'b1);
        chk("t6_perf0_wrap", perf0, 32'd0);
`endif
        pend = 2'b00;
        vld = 2'b00;
        n = 0;
        cyc = 0;
        while (n < 1000 && cyc < 20000) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    fa[i] = $urandom;
                    fb[i] = ($urandom_range(0, 3) == 0) ? fa[i] : $urandom;
                    fo[i] = 4'($urandom_range(0, 15));
                    vld[i] = $urandom_range(0, 3) != 0;
                end
            end
            cycle(vld, $urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++)
                pend[i] = vld[i] && !(acc && gnt == 1'(i));
            if (acc) n++;
            cyc++;
        end
        chk("random_ops_completed", {31'b0, n >= 1000}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
